fft_in_pio_fifo: RTL and testbench

Parametrised Avalon-MM input port for the FFT sample path in the Nios II VGA system. It keeps the plain live-read register at address 0 for existing drivers. It adds a sample FIFO that captures `in_port` on each `in_valid` strobe, plus level/overflow status, control, and a threshold interrupt. The CPU drains FFT input samples in bursts instead of polling one word at a time.

---
 rtl/fft_in_pio_pkg.sv | 18 +
 rtl/pio_sync_fifo.sv | 59 +++++
 rtl/fft_in_pio_fifo.sv | 111 +++++++++++
 tb/tb_fft_in_pio_fifo.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_in_pio_pkg.sv
// Register map constants and bit positions shared by the FFT input PIO/FIFO slave.
package fft_in_pio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_POP    = 3'd1;
  localparam logic [2:0] ADDR_STATUS = 3'd2;
  localparam logic [2:0] ADDR_CTRL   = 3'd3;
  localparam logic [2:0] ADDR_FLUSH  = 3'd4;

  localparam int unsigned STAT_EMPTY_BIT = 16;
  localparam int unsigned STAT_FULL_BIT  = 17;
  localparam int unsigned STAT_OVF_BIT   = 18;

  localparam int unsigned CTRL_CAP_EN_BIT = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;
  localparam int unsigned CTRL_THRESH_LSB = 8;

endpackage

// File: rtl/pio_sync_fifo.sv
// Single-clock sample FIFO with combinational head, level count and flush.
module pio_sync_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] head,
  output logic [AW:0]       level,
  output logic              empty,
  output logic              full
);

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              push_ok, pop_ok;

  assign empty = (level == '0);
  assign full  = (level == LVL_FULL);
  assign head  = mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fft_in_pio_fifo.sv
// Avalon-MM input port: live read at address 0 plus a captured-sample FIFO with
// status, control and a level/overflow interrupt.
module fft_in_pio_fifo
  import fft_in_pio_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_port,
  input  logic              in_valid,
  output logic              irq
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic              wr_en, rd_en;
  logic              push_req, pop_req, flush;
  logic [DATA_W-1:0] head;
  logic [AW:0]       level;
  logic              empty, full;
  logic              ovf, cap_en, irq_en;
  logic [AW:0]       thresh;
  logic [31:0]       rd_mux;
  logic              irq_next;

  assign wr_en    = chipselect & write;
  assign rd_en    = chipselect & read;
  assign push_req = in_valid & cap_en;
  assign pop_req  = rd_en & (address == ADDR_POP) & ~empty;
  assign flush    = wr_en & (address == ADDR_FLUSH);

  pio_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_req),
    .pop     (pop_req),
    .flush   (flush),
    .data    (in_port),
    .head    (head),
    .level   (level),
    .empty   (empty),
    .full    (full)
  );

  // A sample dropped in the same cycle as a W1C still leaves OVF set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf <= 1'b0;
    end else if (push_req && full && !pop_req && !flush) begin
      ovf <= 1'b1;
    end else if (wr_en && address == ADDR_STATUS && writedata[STAT_OVF_BIT]) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_en <= 1'b0;
      irq_en <= 1'b0;
      thresh <= '0;
    end else if (wr_en && address == ADDR_CTRL) begin
      cap_en <= writedata[CTRL_CAP_EN_BIT];
      irq_en <= writedata[CTRL_IRQ_EN_BIT];
      thresh <= writedata[CTRL_THRESH_LSB +: AW+1];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux = 32'(in_port);
      ADDR_POP:  if (!empty) rd_mux = 32'(head);
      ADDR_STATUS: begin
        rd_mux[AW:0]           = level;
        rd_mux[STAT_EMPTY_BIT] = empty;
        rd_mux[STAT_FULL_BIT]  = full;
        rd_mux[STAT_OVF_BIT]   = ovf;
      end
      ADDR_CTRL: begin
        rd_mux[CTRL_CAP_EN_BIT]              = cap_en;
        rd_mux[CTRL_IRQ_EN_BIT]              = irq_en;
        rd_mux[CTRL_THRESH_LSB +: AW+1]      = thresh;
      end
      default: rd_mux = '0;
    endcase
  end

  assign irq_next = irq_en & (((thresh != '0) & (level >= thresh)) | ovf);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_mux;
      irq      <= irq_next;
    end
  end

endmodule

// File: tb/tb_fft_in_pio_fifo.sv
// Directed bench for fft_in_pio_fifo (DATA_W=32, DEPTH=16).
module tb_fft_in_pio_fifo;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [31:0] in_port = '0;
  logic        in_valid = 1'b0;
  logic        irq;

  int passed = 0;
  int total  = 0;

  fft_in_pio_fifo #(.DATA_W(32), .DEPTH(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .in_valid   (in_valid),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] wd);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = wd;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic push_one(input logic [31:0] s);
    @(negedge clk);
    in_valid = 1'b1; in_port = s;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else passed++;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    total++;
    if (readdata !== 32'h0) $display("FAIL reset_readdata: got %h expected %h", readdata, 32'h0);
    else passed++;
    total++;
    if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected %b", irq, 1'b0);
    else passed++;
    @(negedge clk); reset_n = 1'b1;
    in_port = 32'hA5A5_1234;
    bus_read(3'd0, d);
    total++;
    if (d !== 32'hA5A5_1234) $display("FAIL live_read: got %h expected %h", d, 32'hA5A5_1234);
    else passed++;
    bus_read(3'd2, d);
    total++;
    if (d !== 32'h0001_0000) $display("FAIL reset_status: got %h expected %h", d, 32'h0001_0000);
    else passed++;
  endtask

  task automatic test_ordered;
    logic [31:0] d;
    bus_write(3'd3, 32'h1);
    for (int i = 1; i <= 5; i++) push_one(32'(i));
    bus_read(3'd2, d);
    total++;
    if (d !== 32'h0000_0005) $display("FAIL ord_status5: got %h expected %h", d, 32'h5);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++;
        if (readdata !== 32'(i)) $display("FAIL ord_pop%0d: got %h expected %h", i, readdata, 32'(i));
        else passed++;
      end
      chipselect = 1'b1; read = 1'b1; address = 3'd1;
    end
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    total++;
    if (readdata !== 32'd5) $display("FAIL ord_pop5: got %h expected %h", readdata, 32'd5);
    else passed++;
    bus_read(3'd2, d);
    total++;
    if (d !== 32'h0001_0000) $display("FAIL ord_empty: got %h expected %h", d, 32'h0001_0000);
    else passed++;
    bus_read(3'd1, d);
    total++;
    if (d !== 32'h0) $display("FAIL ord_pop_empty: got %h expected %h", d, 32'h0);
    else passed++;
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    int errs;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_port = 32'h10 + 32'(i);
    end
    @(negedge clk); in_valid = 1'b0;
    bus_read(3'd2, d);
    total++;
    if (d !== 32'h0006_0010) $display("FAIL ovf_status: got %h expected %h", d, 32'h0006_0010);
    else passed++;
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      bus_read(3'd1, d);
      if (d !== 32'h10 + 32'(i)) begin
        errs++;
        $display("FAIL ovf_pop%0d: got %h expected %h", i, d, 32'h10 + 32'(i));
      end
    end
    total++;
    if (errs == 0) passed++;
    bus_read(3'd2, d);
    chk("ovf_sticky", d, 32'h0005_0000);
    bus_write(3'd2, 32'h0004_0000);
    bus_read(3'd2, d);
    chk("ovf_clear", d, 32'h0001_0000);
  endtask

  task automatic test_push_pop_full;
    logic [31:0] d;
    int errs;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_port = 32'h30 + 32'(i);
    end
    @(negedge clk);
    in_port = 32'h99; chipselect = 1'b1; read = 1'b1; address = 3'd1;
    @(negedge clk);
    in_valid = 1'b0; chipselect = 1'b0; read = 1'b0;
    chk("pp_head", readdata, 32'h30);
    bus_read(3'd2, d);
    chk("pp_status", d, 32'h0002_0010);
    errs = 0;
    for (int i = 1; i < 16; i++) begin
      bus_read(3'd1, d);
      if (d !== 32'h30 + 32'(i)) begin
        errs++;
        $display("FAIL pp_pop%0d: got %h expected %h", i, d, 32'h30 + 32'(i));
      end
    end
    total++;
    if (errs == 0) passed++;
    bus_read(3'd1, d);
    chk("pp_last", d, 32'h99);
  endtask

  task automatic test_irq;
    logic [31:0] d;
    bus_write(3'd3, 32'h0000_0403);
    for (int i = 0; i < 3; i++) push_one(32'hA1 + 32'(i));
    @(negedge clk);
    chk("irq_lvl3", 32'(irq), 32'h0);
    @(negedge clk);
    in_valid = 1'b1; in_port = 32'hA4;
    @(negedge clk);
    in_valid = 1'b0;
    chk("irq_1cyc", 32'(irq), 32'h0);
    @(negedge clk);
    chk("irq_rise", 32'(irq), 32'h1);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = 3'd1;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    chk("irq_popdata", readdata, 32'hA1);
    chk("irq_hold", 32'(irq), 32'h1);
    @(negedge clk);
    chk("irq_fall", 32'(irq), 32'h0);
    bus_write(3'd3, 32'h0000_0003);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_port = 32'hB0 + 32'(i);
    end
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    chk("irq_ovf", 32'(irq), 32'h1);
    bus_read(3'd2, d);
    chk("irq_status", d, 32'h0006_0010);
  endtask

  task automatic test_flush_reset;
    logic [31:0] d;
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = 3'd4; writedata = 32'h1;
    in_valid = 1'b1; in_port = 32'hCC;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; in_valid = 1'b0;
    bus_read(3'd2, d);
    chk("flush_status", d, 32'h0005_0000);
    chk("flush_irq", 32'(irq), 32'h1);
    in_port = 32'h77;
    bus_read(3'd0, d);
    chk("pre_reset_read", d, 32'h77);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_port = 32'hD0 + 32'(i);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_readdata", readdata, 32'h0);
    in_valid = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    bus_read(3'd2, d);
    chk("rst_status", d, 32'h0001_0000);
    bus_read(3'd3, d);
    chk("rst_ctrl", d, 32'h0);
  endtask

  initial begin
    #23;
    test_reset;
    test_ordered;
    test_overflow;
    test_push_pop_full;
    test_irq;
    test_flush_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
